// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//
// Multi-cycle controller for a small RV32I integer datapath. An instruction
// is accepted in IDLE and then walks DECODE -> EXEC -> DONE -> IDLE. The
// accepting cycle counts as cycle 1, so done is seen in cycle 4.
//
// Handshake:
//   - The word is latched when it is accepted and not sampled again.
//   - The decoded fields are registered at the end of DECODE.
//   - RegWrite is high for the EXEC cycle only.
//   - done and its qualifiers are high for the DONE cycle only.
//
// Optional feature:
//   ALU_SEQ_BRANCH_EN - when defined, BEQ/BNE are decoded and resolved from
//   the EQ flag. When undefined, opcode 1100011 is illegal and br_taken and
//   br_offset are tied to zero.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   instr_valid         an instruction word is offered on instr
//   instr_ready         controller is in IDLE and can accept a word
//   instr[31:0]         RV32I instruction word
//   EQ                  ALU equality flag from the datapath
//   RegWrite            register-file write enable (EXEC only)
//   ALUsrc              1 selects ImmOp as the second ALU operand
//   ALUctrl[2:0]        ADD=000 SUB=001 AND=010 OR=011 XOR=100 SLT=101
//   rs1, rs2, rd        register-file addresses
//   ImmOp[31:0]         sign-extended immediate
//   done                one-cycle pulse, instruction retired
//   illegal             with done: instruction unsupported, no effect
//   br_taken            with done: branch condition met
//   br_offset[31:0]     with done: sign-extended B-type offset
//   retired[CNT_W-1:0]  wrapping count of legal instructions retired
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    input  logic             EQ,
    output logic             RegWrite,
    output logic             ALUsrc,
    output logic [2:0]       ALUctrl,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [31:0]      ImmOp,
    output logic             done,
    output logic             illegal,
    output logic             br_taken,
    output logic [31:0]      br_offset,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t      state;
    logic [31:0] instr_q;
    logic        legal_q;

    logic        dec_legal;
    logic        dec_writes;
    logic        dec_alusrc;
    logic [2:0]  dec_aluctrl;
    logic [31:0] dec_imm;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

`ifdef ALU_SEQ_BRANCH_EN
    logic        dec_branch;
    logic [31:0] dec_boff;
    logic        branch_q;
    logic        bne_q;
    logic        br_taken_q;
    logic [31:0] br_offset_q;
`endif

    // Combinational decode of the latched word. Only the register stage at
    // the end of DECODE consumes it, so the outputs never see it directly.
    // A field combination that is not listed leaves dec_legal at 0.
    always_comb begin
        dec_legal   = 1'b0;
        dec_writes  = 1'b0;
        dec_alusrc  = 1'b0;
        dec_aluctrl = ALU_ADD;
        dec_imm     = '0;
`ifdef ALU_SEQ_BRANCH_EN
        dec_branch  = 1'b0;
        dec_boff    = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                       instr_q[30:25], instr_q[11:8], 1'b0};
`endif
        case (opcode)
            OPC_OP: begin
                dec_writes = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            dec_legal   = 1'b1;
                            dec_aluctrl = ALU_ADD;
                        end else if (funct7 == 7'b0100000) begin
                            dec_legal   = 1'b1;
                            dec_aluctrl = ALU_SUB;
                        end
                    end
                    3'b111: begin
                        dec_legal   = (funct7 == 7'b0000000);
                        dec_aluctrl = ALU_AND;
                    end
                    3'b110: begin
                        dec_legal   = (funct7 == 7'b0000000);
                        dec_aluctrl = ALU_OR;
                    end
                    3'b100: begin
                        dec_legal   = (funct7 == 7'b0000000);
                        dec_aluctrl = ALU_XOR;
                    end
                    3'b010: begin
                        dec_legal   = (funct7 == 7'b0000000);
                        dec_aluctrl = ALU_SLT;
                    end
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                dec_writes = 1'b1;
                dec_alusrc = 1'b1;
                dec_imm    = {{20{instr_q[31]}}, instr_q[31:20]};
                case (funct3)
                    3'b000: begin
                        dec_legal   = 1'b1;
                        dec_aluctrl = ALU_ADD;
                    end
                    3'b111: begin
                        dec_legal   = 1'b1;
                        dec_aluctrl = ALU_AND;
                    end
                    3'b110: begin
                        dec_legal   = 1'b1;
                        dec_aluctrl = ALU_OR;
                    end
                    3'b100: begin
                        dec_legal   = 1'b1;
                        dec_aluctrl = ALU_XOR;
                    end
                    3'b010: begin
                        dec_legal   = 1'b1;
                        dec_aluctrl = ALU_SLT;
                    end
                    default: ;
                endcase
            end
`ifdef ALU_SEQ_BRANCH_EN
            OPC_BRANCH: begin
                dec_branch  = 1'b1;
                dec_aluctrl = ALU_SUB;
                dec_imm     = dec_boff;
                dec_legal   = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
`endif
            default: ;
        endcase
    end

    // Sequencer and all registered outputs.
    // RegWrite is armed on entry to EXEC and dropped on the edge that ends
    // EXEC, which is the edge on which the register file writes.
    // retired steps on entry to DONE, so the new count is visible together
    // with the done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            instr_q     <= '0;
            legal_q     <= 1'b0;
            RegWrite    <= 1'b0;
            ALUsrc      <= 1'b0;
            ALUctrl     <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            ImmOp       <= '0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            retired     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    rs1      <= instr_q[19:15];
                    rs2      <= instr_q[24:20];
                    rd       <= instr_q[11:7];
                    ImmOp    <= dec_imm;
                    ALUctrl  <= dec_aluctrl;
                    ALUsrc   <= dec_alusrc;
                    legal_q  <= dec_legal;
                    RegWrite <= dec_legal && dec_writes && (instr_q[11:7] != 5'd0);
                    state    <= EXEC;
                end
                EXEC: begin
                    RegWrite <= 1'b0;
                    done     <= 1'b1;
                    illegal  <= !legal_q;
                    if (legal_q) begin
                        retired <= retired + CNT_W'(1);
                    end
                    state    <= DONE;
                end
                DONE: begin
                    done        <= 1'b0;
                    illegal     <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_BRANCH_EN
    // Branch resolution. EQ is sampled on the edge that ends EXEC.
    // The qualifiers are cleared again on the edge that ends DONE, so they
    // read as zero whenever done is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_q    <= 1'b0;
            bne_q       <= 1'b0;
            br_taken_q  <= 1'b0;
            br_offset_q <= '0;
        end else begin
            case (state)
                DECODE: begin
                    branch_q <= dec_legal && dec_branch;
                    bne_q    <= funct3[0];
                end
                EXEC: begin
                    br_taken_q  <= branch_q && (bne_q ? !EQ : EQ);
                    br_offset_q <= branch_q ? dec_boff : '0;
                end
                default: begin
                    br_taken_q  <= 1'b0;
                    br_offset_q <= '0;
                end
            endcase
        end
    end

    assign br_taken  = br_taken_q;
    assign br_offset = br_offset_q;
`else
    logic unused_eq;
    assign unused_eq = EQ;
    assign br_taken  = 1'b0;
    assign br_offset = '0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
//
// Scoreboard bench for alu_seq_ctrl.
//   - Stimulus pushes one hand-computed expectation per accepted word.
//   - A negedge monitor pops an expectation on every done pulse and checks it.
//   - A second instance with CNT_W=2 shares the inputs to exercise counter wrap.
//
// Branch vectors expect resolution when ALU_SEQ_BRANCH_EN is defined, and an
// illegal retirement otherwise.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        EQ;

    logic        instr_ready, RegWrite, ALUsrc, done, illegal, br_taken;
    logic [2:0]  ALUctrl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] ImmOp, br_offset;
    logic [15:0] retired;

    logic        w2_instr_ready, w2_RegWrite, w2_ALUsrc, w2_done, w2_illegal, w2_br_taken;
    logic [2:0]  w2_ALUctrl;
    logic [4:0]  w2_rs1, w2_rs2, w2_rd;
    logic [31:0] w2_ImmOp, w2_br_offset;
    logic [1:0]  w2_retired;

    always #5 clk = ~clk;

    alu_seq_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .EQ(EQ), .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
        .rs1(rs1), .rs2(rs2), .rd(rd), .ImmOp(ImmOp), .done(done), .illegal(illegal),
        .br_taken(br_taken), .br_offset(br_offset), .retired(retired)
    );

    alu_seq_ctrl #(.CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(w2_instr_ready),
        .instr(instr), .EQ(EQ), .RegWrite(w2_RegWrite), .ALUsrc(w2_ALUsrc), .ALUctrl(w2_ALUctrl),
        .rs1(w2_rs1), .rs2(w2_rs2), .rd(w2_rd), .ImmOp(w2_ImmOp), .done(w2_done),
        .illegal(w2_illegal), .br_taken(w2_br_taken), .br_offset(w2_br_offset),
        .retired(w2_retired)
    );

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        alusrc;
        logic [2:0]  aluctrl;
        logic [31:0] immop;
        logic        regwrite, illegal, br_taken;
        logic [31:0] br_offset;
        logic        check_fields;
        logic [15:0] retired;
        logic [1:0]  retired2;
        int          accept_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks   = 0;
    int   n_fails    = 0;
    int   legal_cnt  = 0;
    int   cyc        = 0;
    int   done_seen  = 0;
    int   pushed     = 0;
    logic saw_rw     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdv,
                                input logic src, input logic [2:0] ctl, input logic [31:0] imm,
                                input logic rw, input logic ill, input logic bt,
                                input logic [31:0] boff, input logic chk);
        exp_t x;
        x.rs1 = r1; x.rs2 = r2; x.rd = rdv; x.alusrc = src; x.aluctrl = ctl;
        x.immop = imm; x.regwrite = rw; x.illegal = ill; x.br_taken = bt;
        x.br_offset = boff; x.check_fields = chk;
        x.retired = '0; x.retired2 = '0; x.accept_cyc = 0;
        return x;
    endfunction

    // Completes an expectation with the counter model and queues it.
    task automatic pushExp(input exp_t x);
        if (!x.illegal) legal_cnt++;
        x.retired    = legal_cnt[15:0];
        x.retired2   = legal_cnt[1:0];
        x.accept_cyc = cyc;
        sb.push_back(x);
        pushed++;
    endtask

    // Waits for instr_ready, offers one word for one edge, queues its expectation.
    task automatic applyStimulus(input logic [31:0] word, input logic eq_val, input exp_t x);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            checkOutput("ready timeout", 32'(instr_ready), 32'd1);
        end else begin
            instr       = word;
            EQ          = eq_val;
            instr_valid = 1'b1;
            pushExp(x);
            @(posedge clk);
            #1 instr_valid = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            saw_rw = 1'b0;
        end else begin
            if (RegWrite) saw_rw = 1'b1;
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    done_seen++;
                    checkOutput("latency", 32'(cyc - e.accept_cyc), 32'd3);
                    checkOutput("illegal", 32'(illegal), 32'(e.illegal));
                    checkOutput("br_taken", 32'(br_taken), 32'(e.br_taken));
                    checkOutput("br_offset", br_offset, e.br_offset);
                    checkOutput("RegWrite in EXEC", 32'(saw_rw), 32'(e.regwrite));
                    checkOutput("retired", 32'(retired), 32'(e.retired));
                    checkOutput("retired CNT_W=2", 32'(w2_retired), 32'(e.retired2));
                    checkOutput("w2 done", 32'(w2_done), 32'd1);
                    checkOutput("ready in DONE", 32'(instr_ready), 32'd0);
                    if (e.check_fields) begin
                        checkOutput("rs1", 32'(rs1), 32'(e.rs1));
                        checkOutput("rs2", 32'(rs2), 32'(e.rs2));
                        checkOutput("rd", 32'(rd), 32'(e.rd));
                        checkOutput("ALUsrc", 32'(ALUsrc), 32'(e.alusrc));
                        checkOutput("ALUctrl", 32'(ALUctrl), 32'(e.aluctrl));
                        checkOutput("ImmOp", ImmOp, e.immop);
                    end
                end
                saw_rw = 1'b0;
            end else begin
                checkOutput("illegal without done", 32'(illegal), 32'd0);
                checkOutput("br_taken without done", 32'(br_taken), 32'd0);
                checkOutput("br_offset without done", br_offset, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int accepts;
        int guard;

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        EQ          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset instr_ready", 32'(instr_ready), 32'd1);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("reset retired", 32'(retired), 32'd0);
        rst_n = 1'b1;

        // ADDI x5,x0,7 aborted by reset during EXEC
        @(negedge clk);
        instr       = 32'h00700293;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort RegWrite in EXEC", 32'(RegWrite), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort retired", 32'(retired), 32'd0);
        checkOutput("abort instr_ready", 32'(instr_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort done later", 32'(done), 32'd0);

        // ADDI x5,x0,7
        applyStimulus(32'h00700293, 1'b0,
                      mk(5'd0, 5'd7, 5'd5, 1'b1, 3'b000, 32'd7, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1));

        // SUB x3,x1,x2 with instr_valid held for 8 cycles
        @(negedge clk);
        guard = 0;
        while (!instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        instr       = 32'h402081B3;
        instr_valid = 1'b1;
        accepts     = 0;
        for (int i = 0; i < 8; i++) begin
            if (instr_ready) begin
                pushExp(mk(5'd1, 5'd2, 5'd3, 1'b0, 3'b001, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1));
                accepts++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        checkOutput("held valid accepts", 32'(accepts), 32'd2);

        // XOR x7,x1,x2
        applyStimulus(32'h0020C3B3, 1'b0,
                      mk(5'd1, 5'd2, 5'd7, 1'b0, 3'b100, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1));
        // SLTI x9,x2,-1
        applyStimulus(32'hFFF12493, 1'b0,
                      mk(5'd2, 5'd31, 5'd9, 1'b1, 3'b101, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1));
        // ADDI x0,x0,1: legal, no write
        applyStimulus(32'h00100013, 1'b0,
                      mk(5'd0, 5'd1, 5'd0, 1'b1, 3'b000, 32'd1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1));
        // LW x1,0(x0): unsupported opcode
        applyStimulus(32'h00002083, 1'b0,
                      mk(5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0));
        // OP with funct7=0000001: unsupported
        applyStimulus(32'h023100B3, 1'b0,
                      mk(5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0));

`ifdef ALU_SEQ_BRANCH_EN
        // BEQ x1,x2,-8 with EQ=1, then EQ=0; BNE x1,x2,-8 with EQ=0
        applyStimulus(32'hFE208CE3, 1'b1,
                      mk(5'd1, 5'd2, 5'd25, 1'b0, 3'b001, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b1, 32'hFFFFFFF8, 1'b1));
        applyStimulus(32'hFE208CE3, 1'b0,
                      mk(5'd1, 5'd2, 5'd25, 1'b0, 3'b001, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF8, 1'b1));
        applyStimulus(32'hFE209CE3, 1'b0,
                      mk(5'd1, 5'd2, 5'd25, 1'b0, 3'b001, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b1, 32'hFFFFFFF8, 1'b1));
`else
        // Branches are unsupported in this build
        applyStimulus(32'hFE208CE3, 1'b1,
                      mk(5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0));
        applyStimulus(32'hFE209CE3, 1'b0,
                      mk(5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0));
`endif

        // One more legal word after the branches
        applyStimulus(32'h00700293, 1'b0,
                      mk(5'd0, 5'd7, 5'd5, 1'b1, 3'b000, 32'd7, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1));

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
        checkOutput("done count", 32'(done_seen), 32'(pushed));

        // Reset after activity returns every output to its reset value
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("final reset instr_ready", 32'(instr_ready), 32'd1);
        checkOutput("final reset ImmOp", ImmOp, 32'd0);
        checkOutput("final reset rd", 32'(rd), 32'd0);
        checkOutput("final reset ALUsrc", 32'(ALUsrc), 32'd0);
        checkOutput("final reset retired", 32'(retired), 32'd0);
        checkOutput("final reset retired CNT_W=2", 32'(w2_retired), 32'd0);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
